// File: rtl/instruction_fetch_queue_if.sv
// instruction_fetch_queue_if: ROM fetch port plus the decode issue handshake.
interface instruction_fetch_queue_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 3
);
    logic [DATA_WIDTH-1:0]  FetchAddress;
    logic [DATA_WIDTH-1:0]  FetchInstruction;
    logic                   Redirect;
    logic [DATA_WIDTH-1:0]  RedirectTarget;
    logic                   IssueReady;
    logic                   IssueValid;
    logic [DATA_WIDTH-1:0]  IssueInstruction;
    logic [DATA_WIDTH-1:0]  IssuePC;
    logic [DATA_WIDTH-1:0]  IssuePCPlus4;
    logic [COUNT_WIDTH-1:0] QueueCount;
    logic [15:0]            StallCycles;
    logic [15:0]            FlushCount;
    modport master (
        output FetchAddress, IssueValid, IssueInstruction, IssuePC, IssuePCPlus4,
               QueueCount, StallCycles, FlushCount,
        input  FetchInstruction, Redirect, RedirectTarget, IssueReady
    );
    modport slave (
        input  FetchAddress, IssueValid, IssueInstruction, IssuePC, IssuePCPlus4,
               QueueCount, StallCycles, FlushCount,
        output FetchInstruction, Redirect, RedirectTarget, IssueReady
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch PC + prefetch queue feeding decode; perf counters built only with FETCH_PERF_COUNTERS_EN.
module instruction_fetch_queue #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0040_0000,
    parameter int                    QUEUE_DEPTH = 2,
    parameter int                    COUNT_WIDTH = 3
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_queue_if.master bus
);
    localparam int PW = (QUEUE_DEPTH == 4) ? 2 : 1;
    localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(QUEUE_DEPTH);
    logic [DATA_WIDTH-1:0]  fetch_pc;
    logic [DATA_WIDTH-1:0]  q_instr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]  q_pc [QUEUE_DEPTH];
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [COUNT_WIDTH-1:0] count;
    logic                   pop;
    logic                   push;
    // a slot frees up either because the queue is not full or the head leaves this cycle
    always_comb begin
        pop  = (count != '0) & bus.IssueReady;
        push = ((count < FULL) | pop) & ~bus.Redirect;
    end
    // fetch PC, queue storage and pointers; redirect flushes everything not popped this cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (bus.Redirect) begin
            fetch_pc <= bus.RedirectTarget & ~DATA_WIDTH'(3);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                q_instr[tail] <= bus.FetchInstruction;
                q_pc[tail]    <= fetch_pc;
                tail          <= tail + 1'b1;
                fetch_pc      <= fetch_pc + DATA_WIDTH'(4);
            end
            if (pop) head <= head + 1'b1;
            count <= count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);
        end
    end
    assign bus.FetchAddress     = fetch_pc;
    assign bus.IssueValid       = count != '0;
    assign bus.IssueInstruction = q_instr[head];
    assign bus.IssuePC          = q_pc[head];
    assign bus.IssuePCPlus4     = q_pc[head] + DATA_WIDTH'(4);
    assign bus.QueueCount       = count;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    // saturating counters for full-and-blocked cycles and flushes that discarded work
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (count == FULL && !pop && !bus.Redirect && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (bus.Redirect && count != '0 && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
    assign bus.StallCycles = stall_cycles;
    assign bus.FlushCount  = flush_count;
`else
    assign bus.StallCycles = '0;
    assign bus.FlushCount  = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: queue-based reference model feeding a scoreboard checked by a separate monitor.
module tb_instruction_fetch_queue;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] fa;
        logic [2:0]  cnt;
        logic [15:0] stall;
        logic [15:0] flush;
    } exp_t;
    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;
    instruction_fetch_queue_if #(.DATA_WIDTH(32), .COUNT_WIDTH(3)) bus();
    instruction_fetch_queue #(
        .DATA_WIDTH(32), .RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH), .COUNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction
    assign bus.FetchInstruction = rom(bus.FetchAddress);
    exp_t        expq[$];
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    int          m_stall;
    int          m_flush;
    int          checks = 0;
    int          passed = 0;
    exp_t        e_mon;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask
    // apply one cycle of inputs and push the state the DUT must show after the next rising edge
    task automatic step(input bit rst_n, input bit redir, input logic [31:0] tgt, input bit rdy);
        int   n;
        bit   pop;
        exp_t e;
        @(negedge clk);
        reset              = rst_n;
        bus.Redirect       = redir;
        bus.RedirectTarget = tgt;
        bus.IssueReady     = rdy;
        if (!rst_n) begin
            m_q.delete();
            m_pc    = RST_PC;
            m_stall = 0;
            m_flush = 0;
        end else begin
            n   = m_q.size();
            pop = (n != 0) && rdy;
            if (n == DEPTH && !pop && !redir && m_stall < 65535) m_stall++;
            if (redir && n != 0 && m_flush < 65535) m_flush++;
            if (pop) void'(m_q.pop_front());
            if (redir) begin
                m_q.delete();
                m_pc = {tgt[31:2], 2'b00};
            end else if (m_q.size() < DEPTH) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        e.valid = m_q.size() != 0;
        e.pc    = e.valid ? m_q[0] : 32'd0;
        e.fa    = m_pc;
        e.cnt   = 3'(m_q.size());
`ifdef FETCH_PERF_COUNTERS_EN
        e.stall = 16'(m_stall);
        e.flush = 16'(m_flush);
`else
        e.stall = 16'd0;
        e.flush = 16'd0;
`endif
        expq.push_back(e);
    endtask
    // monitor: compare DUT outputs just after each edge against the oldest scoreboard entry
    always @(posedge clk) begin
        #1;
        if (expq.size() != 0) begin
            e_mon = expq.pop_front();
            check("IssueValid", 32'(bus.IssueValid), 32'(e_mon.valid));
            check("QueueCount", 32'(bus.QueueCount), 32'(e_mon.cnt));
            check("FetchAddress", bus.FetchAddress, e_mon.fa);
            check("StallCycles", 32'(bus.StallCycles), 32'(e_mon.stall));
            check("FlushCount", 32'(bus.FlushCount), 32'(e_mon.flush));
            if (e_mon.valid) begin
                check("IssuePC", bus.IssuePC, e_mon.pc);
                check("IssueInstruction", bus.IssueInstruction, rom(e_mon.pc));
                check("IssuePCPlus4", bus.IssuePCPlus4, e_mon.pc + 32'd4);
            end
        end
    end
    initial begin
        logic [31:0] tgt;
        bus.Redirect       = 0;
        bus.RedirectTarget = 0;
        bus.IssueReady     = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (5) step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        repeat (6) step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0);
        step(1, 1, 32'h0040_0023, 0);
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 32'hFFFF_FFFC, 1);
        repeat (4) step(1, 0, 0, 1);
        step(0, 1, 32'h1234_5678, 1);
        repeat (3) step(1, 0, 0, 1);
        repeat (3000) begin
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) < 6);
        end
        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
